// File: rtl/csi_pkg.sv
// Shared CSI-2 definitions: RAW10 data type, group geometry and the unpacker state enum.
package csi_pkg;
  localparam logic [5:0] DT_RAW10           = 6'h2B;
  localparam logic [3:0] RAW10_GROUP_BYTES  = 4'd5;
  localparam logic [2:0] RAW10_GROUP_PIXELS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2
  } state_t;
endpackage

// File: rtl/raw10_group_decode.sv
// Combinational RAW10 decode: five packed bytes B0..B4 become four 10-bit pixels.
module raw10_group_decode
  import csi_pkg::*;
(
  input  logic [39:0] group_bytes,
  output logic [39:0] pixels
);
  // Pn takes Bn as its 8 MSBs and the matching 2-bit field of B4 as its LSBs.
  always_comb begin
    pixels = '0;
    for (int p = 0; p < int'(RAW10_GROUP_PIXELS); p++)
      pixels[10*p +: 10] = {group_bytes[8*p +: 8], group_bytes[32 + 2*p +: 2]};
  end
endmodule

// File: rtl/csi_raw10_unpacker.sv
// RAW10 payload unpacker: 32-bit CSI words in, 4-pixel groups with line/frame markers out.
// Define CSI_UNPACK_COORD_EN to add the out_x/out_y pixel coordinate outputs.
module csi_raw10_unpacker
  import csi_pkg::*;
#(
  parameter logic [5:0] DATA_TYPE = DT_RAW10
) (
  input  logic        clock_p,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic [5:0]  in_data_type,
  input  logic [15:0] in_word_count,
  input  logic        sof,
  input  logic        eof,
  output logic [39:0] out_pixels,
  output logic        out_valid,
  output logic        out_sol,
  output logic        out_eol,
  output logic        out_sof,
  output logic        out_eof,
  output logic        err_len,
  output logic        err_trunc,
  output logic        err_orphan,
  output state_t      dbg_state
`ifdef CSI_UNPACK_COORD_EN
  ,
  output logic [15:0] out_x,
  output logic [15:0] out_y
`endif
);
  state_t      state;
  logic [15:0] line_bytes, byte_cnt;
  logic [3:0]  level;
  logic [63:0] byte_buf;
  logic        sol_pend, sof_pend;
`ifdef CSI_UNPACK_COORD_EN
  logic [15:0] x_cnt, y_cnt;
`endif

  logic        match, line_start, grp_v, line_done, last_grp, sol_now;
  logic [15:0] eff_lb, eff_bc, remain, new_bc, drained;
  logic [2:0]  n_take;
  logic [31:0] word_masked;
  logic [63:0] buf_app, buf_drn;
  logic [3:0]  lvl_app, lvl_drn;
  logic [39:0] dec_pixels;

  assign dbg_state = state;

  // The first word of a line is processed against in_word_count directly, so
  // it contributes in the same cycle the line length is latched.
  always_comb begin
    match       = in_valid && (in_data_type == DATA_TYPE);
    line_start  = (state == ST_FRAME);
    eff_lb      = line_start ? in_word_count : line_bytes;
    eff_bc      = line_start ? 16'd0 : byte_cnt;
    remain      = eff_lb - eff_bc;
    n_take      = (remain > 16'd4) ? 3'd4 : remain[2:0];
    word_masked = '0;
    for (int i = 0; i < 4; i++)
      if (3'(i) < n_take) word_masked[8*i +: 8] = in_data[8*i +: 8];
    buf_app  = byte_buf | ({32'd0, word_masked} << {level, 3'b000});
    lvl_app  = level + {1'b0, n_take};
    new_bc   = eff_bc + {13'd0, n_take};
    grp_v    = (lvl_app >= RAW10_GROUP_BYTES);
    buf_drn  = grp_v ? (buf_app >> 40) : buf_app;
    lvl_drn  = grp_v ? (lvl_app - RAW10_GROUP_BYTES) : lvl_app;
    line_done = (new_bc == eff_lb);
    // A group is the line's last full one when fewer than 5 line bytes remain after it.
    drained  = new_bc - {12'd0, lvl_drn};
    last_grp = ((eff_lb - drained) < 16'd5);
    sol_now  = line_start || sol_pend;
  end

  raw10_group_decode u_decode (
    .group_bytes (buf_app[39:0]),
    .pixels      (dec_pixels)
  );

  always_ff @(posedge clock_p) begin
    if (reset) begin
      state      <= ST_IDLE;
      line_bytes <= '0;
      byte_cnt   <= '0;
      level      <= '0;
      byte_buf   <= '0;
      sol_pend   <= 1'b0;
      sof_pend   <= 1'b0;
      out_pixels <= '0;
      out_valid  <= 1'b0;
      out_sol    <= 1'b0;
      out_eol    <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      err_len    <= 1'b0;
      err_trunc  <= 1'b0;
      err_orphan <= 1'b0;
`ifdef CSI_UNPACK_COORD_EN
      x_cnt <= '0;
      y_cnt <= '0;
      out_x <= '0;
      out_y <= '0;
`endif
    end else begin
      out_valid  <= 1'b0;
      out_sol    <= 1'b0;
      out_eol    <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      err_len    <= 1'b0;
      err_trunc  <= 1'b0;
      err_orphan <= 1'b0;
      // Frame events take priority over a word presented in the same cycle.
      if (eof) begin
        state     <= ST_IDLE;
        level     <= '0;
        byte_buf  <= '0;
        out_eof   <= 1'b1;
        err_trunc <= (state == ST_LINE);
      end else if (sof) begin
        state     <= ST_FRAME;
        level     <= '0;
        byte_buf  <= '0;
        sof_pend  <= 1'b1;
        err_trunc <= (state == ST_LINE);
`ifdef CSI_UNPACK_COORD_EN
        y_cnt <= '0;
`endif
      end else if (match) begin
        if (state == ST_IDLE) begin
          err_orphan <= 1'b1;
        end else begin
          line_bytes <= eff_lb;
          byte_cnt   <= new_bc;
          if (grp_v) begin
            out_valid  <= 1'b1;
            out_pixels <= dec_pixels;
            out_sol    <= sol_now;
            out_eol    <= last_grp;
            out_sof    <= sof_pend;
            sol_pend   <= 1'b0;
            sof_pend   <= 1'b0;
`ifdef CSI_UNPACK_COORD_EN
            out_x <= sol_now ? 16'd0 : x_cnt;
            x_cnt <= (sol_now ? 16'd0 : x_cnt) + 16'(RAW10_GROUP_PIXELS);
            out_y <= y_cnt;
            if (last_grp) y_cnt <= y_cnt + 16'd1;
`endif
          end else if (line_start) begin
            sol_pend <= 1'b1;
          end
          if (line_done) begin
            state    <= ST_FRAME;
            level    <= '0;
            byte_buf <= '0;
            err_len  <= (lvl_drn != 4'd0);
          end else begin
            state    <= ST_LINE;
            level    <= lvl_drn;
            byte_buf <= buf_drn;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_csi_raw10_unpacker.sv
// Directed bench for csi_raw10_unpacker: expected groups queued with their due cycle.
module tb_csi_raw10_unpacker;
  import csi_pkg::*;

  logic        clock_p = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_data_type = '0;
  logic [15:0] in_word_count = '0;
  logic        sof = 1'b0;
  logic        eof = 1'b0;
  logic [39:0] out_pixels;
  logic        out_valid, out_sol, out_eol, out_sof, out_eof;
  logic        err_len, err_trunc, err_orphan;
  state_t      dbg_state;
`ifdef CSI_UNPACK_COORD_EN
  logic [15:0] out_x, out_y;
`endif

  csi_raw10_unpacker dut (
    .clock_p       (clock_p),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_data_type  (in_data_type),
    .in_word_count (in_word_count),
    .sof           (sof),
    .eof           (eof),
    .out_pixels    (out_pixels),
    .out_valid     (out_valid),
    .out_sol       (out_sol),
    .out_eol       (out_eol),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .err_len       (err_len),
    .err_trunc     (err_trunc),
    .err_orphan    (err_orphan),
    .dbg_state     (dbg_state)
`ifdef CSI_UNPACK_COORD_EN
    ,
    .out_x         (out_x),
    .out_y         (out_y)
`endif
  );

  // clock / cycle counter
  always #5 clock_p = ~clock_p;
  int cyc = 0;
  always @(posedge clock_p) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_eof = 0, n_trunc = 0, n_len = 0, n_orphan = 0;
  int last_eof_cyc = 0, last_trunc_cyc = 0;
  int seed = 5;
  logic [42:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [42:0] mon_e;
  int          mon_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] ref_pix(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3,
                                          input logic [7:0] b4);
    ref_pix = {b3, b4[7:6], b2, b4[5:4], b1, b4[3:2], b0, b4[1:0]};
  endfunction

  // Group due on the cycle after the word just driven.
  task automatic push_grp(input logic [39:0] pix, input logic s, input logic l, input logic e);
    exp_q.push_back({s, l, e, pix});
    exp_cyc_q.push_back(cyc + 1);
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic e, input logic v, input logic [5:0] dt,
                       input logic [31:0] d, input logic [15:0] wc);
    @(negedge clock_p);
    sof = s; eof = e; in_valid = v; in_data_type = dt; in_data = d; in_word_count = wc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 16'h0);
  endtask

  // Sends nwords words of a wc-byte line; bytes past wc are 0xEE padding.
  task automatic send_line(input int wc, input int nwords, input bit exp_sof);
    logic [7:0] b [64];
    int nb, ng, last;
    for (int k = 0; k < 64; k++) b[k] = (k < wc) ? 8'((k * 37 + seed) % 256) : 8'hEE;
    seed += 11;
    nb = (nwords * 4 < wc) ? nwords * 4 : wc;
    ng = wc / 5;
    for (int i = 0; i < nwords; i++) begin
      drive(1'b0, 1'b0, 1'b1, DT_RAW10, {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]}, 16'(wc));
      for (int j = 0; j * 5 + 4 < nb; j++) begin
        last = j * 5 + 4;
        if (last >= 4 * i && last <= 4 * i + 3)
          push_grp(ref_pix(b[5*j], b[5*j+1], b[5*j+2], b[5*j+3], b[5*j+4]),
                   exp_sof && (j == 0), j == 0, (nwords * 4 >= wc) && (j == ng - 1));
      end
    end
  endtask

  // scoreboard / monitor
  always @(negedge clock_p) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grp", 64'(out_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("grp_data", 64'({out_sof, out_sol, out_eol, out_pixels}), 64'(mon_e));
        check("grp_cycle", 64'(cyc), 64'(mon_c));
      end
    end
    if (out_eof === 1'b1) begin
      n_eof++;
      last_eof_cyc = cyc;
      check("eof_no_valid", 64'(out_valid), 64'd0);
    end
    if (err_trunc === 1'b1) begin
      n_trunc++;
      last_trunc_cyc = cyc;
    end
    if (err_len === 1'b1) n_len++;
    if (err_orphan === 1'b1) n_orphan++;
  end

  int e_cyc;

  initial begin
    // reset state
    repeat (3) @(negedge clock_p);
    reset = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pixels", 64'(out_pixels), 64'd0);
    check("rst_flags", 64'({out_sol, out_eol, out_sof, out_eof}), 64'd0);
    check("rst_errs", 64'({err_len, err_trunc, err_orphan}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // single 10-byte line, hand-decoded
    drive(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 6'h2B, 32'h04030201, 16'd10);
    drive(1'b0, 1'b0, 1'b1, 6'h2B, 32'h08070605, 16'd10);
    push_grp({10'h010, 10'h00C, 10'h009, 10'h005}, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 6'h2B, 32'h00000A09, 16'd10);
    push_grp({10'h024, 10'h020, 10'h01E, 10'h01A}, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("t1_state_frame", 64'(dbg_state), 64'(ST_FRAME));
    drive(1'b0, 1'b1, 1'b0, 6'h00, 32'h0, 16'h0);
    e_cyc = cyc + 1;
    idle(2);
    check("t1_eof_cnt", 64'(n_eof), 64'd1);
    check("t1_eof_cycle", 64'(last_eof_cyc), 64'(e_cyc));
    check("t1_len_cnt", 64'(n_len), 64'd0);

    // back-to-back 40-byte line then eof
    drive(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 16'h0);
    send_line(40, 10, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 6'h00, 32'h0, 16'h0);
    e_cyc = cyc + 1;
    idle(2);
    check("t2_eof_cnt", 64'(n_eof), 64'd2);
    check("t2_eof_cycle", 64'(last_eof_cyc), 64'(e_cyc));
    check("t2_trunc_cnt", 64'(n_trunc), 64'd0);

    // lengths 12 and 14 (leftover dropped), then a clean 10-byte line
    drive(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 16'h0);
    send_line(12, 3, 1'b1);
    send_line(14, 4, 1'b0);
    send_line(10, 3, 1'b0);
    idle(2);
    check("t3_len_cnt", 64'(n_len), 64'd2);

    // sof aborts a 20-byte line, eof aborts another
    drive(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 16'h0);
    send_line(20, 2, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 16'h0);
    e_cyc = cyc + 1;
    send_line(10, 3, 1'b1);
    check("t4_trunc_sof_cycle", 64'(last_trunc_cyc), 64'(e_cyc));
    send_line(20, 1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'h00, 32'h0, 16'h0);
    e_cyc = cyc + 1;
    idle(2);
    check("t4_trunc_cnt", 64'(n_trunc), 64'd2);
    check("t4_eof_cnt", 64'(n_eof), 64'd3);
    check("t4_trunc_eof_cycle", 64'(last_trunc_cyc), 64'(e_cyc));
    check("t4_eof_cycle", 64'(last_eof_cyc), 64'(e_cyc));

    // orphan and wrong data type; sof with a word in the same cycle
    drive(1'b0, 1'b0, 1'b1, 6'h2B, 32'h11223344, 16'd10);
    drive(1'b0, 1'b0, 1'b1, 6'h2A, 32'h55667788, 16'd10);
    idle(2);
    check("t5_orphan_cnt", 64'(n_orphan), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 6'h2A, 32'h99AABBCC, 16'd10);
    idle(1);
    check("t5_state_frame", 64'(dbg_state), 64'(ST_FRAME));
    drive(1'b1, 1'b0, 1'b1, 6'h2B, 32'hDEADBEEF, 16'd12);
    send_line(10, 3, 1'b1);
    idle(2);
    check("t5_orphan_cnt2", 64'(n_orphan), 64'd1);
    check("t5_trunc_cnt", 64'(n_trunc), 64'd2);
    check("t5_len_cnt", 64'(n_len), 64'd2);

    // reset mid-line, then a fresh frame
    drive(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 16'h0);
    send_line(20, 2, 1'b1);
    @(negedge clock_p);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock_p);
    reset = 1'b0;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_pixels", 64'(out_pixels), 64'd0);
    check("t6_rst_flags", 64'({out_sol, out_eol, out_sof, out_eof}), 64'd0);
    check("t6_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    drive(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 16'h0);
    send_line(10, 3, 1'b1);
    idle(3);
    check("t6_trunc_cnt", 64'(n_trunc), 64'd2);
    check("t6_len_cnt", 64'(n_len), 64'd2);

    // final report
    check("missing_grps", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
